mfb_frame_len_meter: RTL and testbench
======================================

Name: mfb_frame_len_meter

Overview:
- Single-region MFB pipeline stage placed directly downstream of the MFB reconfigurator, on its 1-region TX side.
- Passes the MFB stream through one register stage.
- Measures each frame's length in items and emits one record per frame on a side LEN interface.
- The record carries the length, an oversize flag and the metadata captured at SOF.
- Feeds per-frame length consumers, e.g. statistics or length checkers.

Parameters:
- REGION_SIZE, 8, blocks per region (power of 2).
- BLOCK_SIZE, 8, items per block (power of 2).
- ITEM_WIDTH, 8, bits per item.
- META_WIDTH, 8, MFB metadata width; captured at SOF.
- LEN_WIDTH, 16, width of the length record; lengths saturate at 2^LEN_WIDTH-1.

Ports:
- CLK in 1: clock.
- RESET_N in 1: reset.
- RX_DATA in REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH: input word.
- RX_META in META_WIDTH: metadata, valid with RX_SOF.
- RX_SOF_POS in log2(REGION_SIZE): start block of frame.
- RX_EOF_POS in log2(REGION_SIZE*BLOCK_SIZE): last item of frame.
- RX_SOF in 1: frame start in word.
- RX_EOF in 1: frame end in word.
- RX_SRC_RDY in 1: RX valid.
- RX_DST_RDY out 1: RX ready.
- TX_DATA, TX_META, TX_SOF_POS, TX_EOF_POS, TX_SOF, TX_EOF, TX_SRC_RDY out, same widths as RX: registered copy of RX.
- TX_DST_RDY in 1: TX ready.
- LEN_DATA out LEN_WIDTH: frame length in items.
- LEN_META out META_WIDTH: metadata from the frame's SOF word.
- LEN_OVF out 1: length saturated.
- LEN_SRC_RDY out 1: record valid.
- LEN_DST_RDY in 1: record accepted.

Behaviour:
- Interface: one clock CLK; RESET_N asynchronous, active-low.
- Reset: TX_SRC_RDY=0, LEN_SRC_RDY=0, in_frame=0, acc=0, LEN_OVF=0. All data registers are 0 (not required, but deterministic).
- Constants: W=REGION_SIZE*BLOCK_SIZE items per word; sof_off=RX_SOF_POS*BLOCK_SIZE; eof_n=RX_EOF_POS+1.
- Handshake: RX_DST_RDY = (!TX_SRC_RDY | TX_DST_RDY) & (!LEN_SRC_RDY | LEN_DST_RDY). It is combinational from registered state and the DST_RDY inputs.
- RX transfer = RX_SRC_RDY & RX_DST_RDY. On transfer, all RX fields are registered to TX and TX_SRC_RDY=1.
- TX_SRC_RDY falls when TX_DST_RDY=1 and there is no new transfer.
- TX latency is exactly 1 cycle. TX fields stay stable while TX_SRC_RDY & !TX_DST_RDY.
- LEN_SRC_RDY rises in the same cycle the TX copy of the EOF word becomes valid, with the same 1-cycle latency. It holds until LEN_DST_RDY. There is at most one record per word.
- LEN and TX drain independently, but a new RX word is accepted only when both have room.
- Frame state (in_frame flag plus acc counter) updates only on RX transfer:
  - No SOF, no EOF, in_frame=1: acc += W (saturating).
  - SOF only, in_frame=0: acc = W - sof_off; meta_reg = RX_META; in_frame=1.
  - EOF only, in_frame=1: emit len = acc + eof_n; in_frame=0.
  - SOF & EOF, in_frame=0 (single-word frame, sof_off <= RX_EOF_POS): emit len = eof_n - sof_off with LEN_META = RX_META; in_frame stays 0.
  - SOF & EOF, in_frame=1 (EOF of old frame precedes SOF of new): emit len = acc + eof_n with the old meta_reg. Then acc = W - sof_off; meta_reg = RX_META; in_frame=1.
- Arithmetic: computed at LEN_WIDTH+1 bits. Any result or acc value above 2^LEN_WIDTH-1 clamps to all-ones and sets a sticky per-frame ovf. The sticky ovf clears at each SOF. LEN_OVF reports it with the record.
- Protocol errors are not flagged. The required recovery is:
  - SOF with in_frame=1 and no EOF: restarts the frame; the old frame is discarded and no record is emitted.
  - EOF with in_frame=0 and no SOF: ignored for LEN; passed on TX.
- Reset mid-frame: all state clears and any pending TX/LEN word is lost.

Decomposition:
- Shared package mfb_len_pkg:
  - constant WORD_ITEMS;
  - function sat_add(a, b, width);
  - typedef len_rec_t {len, ovf, meta}.
- One natural sub-module: mfb_len_acc, the in_frame/acc/meta state machine producing len_rec_t plus an emit pulse.
- The top level holds the TX/LEN output registers and handshake.

Test Plan (REGION_SIZE=8, BLOCK_SIZE=8, so W=64; LEN_WIDTH=16 unless noted):
1. Single-word frame, SOF_POS=2, EOF_POS=40 -> LEN_DATA=25, LEN_META=sof meta, TX identical 1 cycle later, LEN_OVF=0.
2. Three-word frame: SOF_POS=0, then middle, then EOF_POS=9 -> LEN_DATA=138.
3. Back-to-back in one word: frame A started with SOF_POS=4 in the previous word (acc=32). Word has EOF_POS=7, SOF_POS=2 -> record A=40 with meta A. Frame B then ends next word at EOF_POS=63 -> B=48+64=112 with meta B.
4. Backpressure: hold LEN_DST_RDY=0 for 5 cycles after a record -> RX_DST_RDY=0, the record stays stable, TX drains. On release exactly one record is consumed and no word is lost or duplicated; random TX/LEN ready toggling gives a scoreboard match.
5. Saturation with LEN_WIDTH=8: a frame of 5 full words (320 items) -> LEN_DATA=255, LEN_OVF=1. The next 10-item frame gives 10 with LEN_OVF=0.
6. Assert RESET_N low mid-frame for 1 cycle, then send a 10-item frame -> no record for the interrupted frame, next record=10, TX_SRC_RDY=0 during reset.

Source files
------------

// File: rtl/mfb_len_pkg.sv
// Shared types and helpers for the MFB frame length meter.
//   WORD_ITEMS : default items per MFB word (8 blocks x 8 items)
//   len_rec_t  : per-frame record {len, ovf, meta}, sized for the widest
//                supported configuration (LEN_WIDTH, META_WIDTH < 32)
//   sat_add    : add two lengths, clamp to 2^width-1, flag the clamp
package mfb_len_pkg;

  localparam int DEF_REGION_SIZE = 8;
  localparam int DEF_BLOCK_SIZE  = 8;
  localparam int WORD_ITEMS      = DEF_REGION_SIZE * DEF_BLOCK_SIZE;

  localparam int LEN_MAX  = 32;
  localparam int META_MAX = 32;

  typedef struct packed {
    logic [LEN_MAX-1:0]  len;
    logic                ovf;
    logic [META_MAX-1:0] meta;
  } len_rec_t;

  // Returns {ovf, value}; value is clamped to the all-ones pattern of width bits.
  function automatic logic [LEN_MAX:0] sat_add(input logic [LEN_MAX-1:0] a,
                                               input logic [LEN_MAX-1:0] b,
                                               input int width);
    logic [LEN_MAX:0] sum;
    logic [LEN_MAX:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ~({(LEN_MAX+1){1'b1}} << width);
    if (sum > lim) return {1'b1, lim[LEN_MAX-1:0]};
    else           return {1'b0, sum[LEN_MAX-1:0]};
  endfunction

endpackage

// File: rtl/mfb_len_acc.sv
// Per-frame length accumulator.
// Tracks in_frame / acc / sticky ovf / SOF metadata across accepted MFB words
// and presents the record of the frame ending in the current word.
//   clk, rst_n      : clock, async active-low reset
//   xfer            : current RX word is being accepted
//   sof, eof        : frame start / end flags of the current word
//   sof_pos,eof_pos : start block / last item of the current word
//   meta            : metadata of the current word (valid with sof)
//   emit            : current word closes a frame (record in rec)
//   rec             : length record, combinational from state + inputs
module mfb_len_acc
  import mfb_len_pkg::*;
#(
  parameter int REGION_SIZE = DEF_REGION_SIZE,
  parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
  parameter int W           = WORD_ITEMS,
  parameter int META_WIDTH  = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  xfer,
  input  logic                                  sof,
  input  logic                                  eof,
  input  logic [$clog2(REGION_SIZE)-1:0]        sof_pos,
  input  logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0] eof_pos,
  input  logic [META_WIDTH-1:0]                 meta,
  output logic                                  emit,
  output len_rec_t                              rec
);

  logic                  in_frame;
  logic                  ovf_q;
  logic [LEN_WIDTH-1:0]  acc;
  logic [META_WIDTH-1:0] meta_q;

  logic [LEN_MAX-1:0] sof_off, eof_n;
  logic [LEN_MAX:0]   start_s, cont_s, fin_s, single_s;

  assign sof_off  = LEN_MAX'(sof_pos) * LEN_MAX'(BLOCK_SIZE);
  assign eof_n    = LEN_MAX'(eof_pos) + 1;
  assign start_s  = sat_add(LEN_MAX'(W) - sof_off, '0, LEN_WIDTH);
  assign cont_s   = sat_add(LEN_MAX'(acc), LEN_MAX'(W), LEN_WIDTH);
  assign fin_s    = sat_add(LEN_MAX'(acc), eof_n, LEN_WIDTH);
  assign single_s = sat_add(eof_n - sof_off, '0, LEN_WIDTH);

  // An EOF outside a frame only counts when the same word also opens it.
  assign emit = eof & (in_frame | sof);

  // When in_frame, any EOF closes the old frame first, so the record comes
  // from the accumulator even if a new SOF shares the word.
  always_comb begin
    rec = '0;
    if (in_frame) begin
      rec.len  = fin_s[LEN_MAX-1:0];
      rec.ovf  = ovf_q | fin_s[LEN_MAX];
      rec.meta = META_MAX'(meta_q);
    end else begin
      rec.len  = single_s[LEN_MAX-1:0];
      rec.ovf  = single_s[LEN_MAX];
      rec.meta = META_MAX'(meta);
    end
  end

  // A SOF (re)opens a frame unless it is a complete single-word frame.
  // A SOF without EOF while in_frame silently restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_frame <= 1'b0;
      ovf_q    <= 1'b0;
      acc      <= '0;
      meta_q   <= '0;
    end else if (xfer) begin
      if (sof && (!eof || in_frame)) begin
        in_frame <= 1'b1;
        acc      <= start_s[LEN_WIDTH-1:0];
        ovf_q    <= start_s[LEN_MAX];
        meta_q   <= meta;
      end else if (eof) begin
        in_frame <= 1'b0;
      end else if (in_frame) begin
        acc      <= cont_s[LEN_WIDTH-1:0];
        ovf_q    <= ovf_q | cont_s[LEN_MAX];
      end
    end
  end

  wire unused_hi = ^{start_s[LEN_MAX-1:LEN_WIDTH], cont_s[LEN_MAX-1:LEN_WIDTH]};

endmodule

// File: rtl/mfb_frame_len_meter.sv
// Single-region MFB register stage with per-frame length measurement.
// RX is copied to TX with one cycle of latency; each frame end produces one
// record on the LEN side interface, valid in the same cycle as the TX EOF word.
//   CLK, RESET_N       : clock, async active-low reset
//   RX_*               : MFB input (DATA, META, SOF_POS, EOF_POS, SOF, EOF, SRC_RDY/DST_RDY)
//   TX_*               : registered copy of RX
//   LEN_DATA/META/OVF  : frame length in items, SOF metadata, saturation flag
//   LEN_SRC/DST_RDY    : record handshake
module mfb_frame_len_meter
  import mfb_len_pkg::*;
#(
  parameter int REGION_SIZE = DEF_REGION_SIZE,
  parameter int BLOCK_SIZE  = DEF_BLOCK_SIZE,
  parameter int ITEM_WIDTH  = 8,
  parameter int META_WIDTH  = 8,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                                          CLK,
  input  logic                                          RESET_N,

  input  logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0]  RX_DATA,
  input  logic [META_WIDTH-1:0]                         RX_META,
  input  logic [$clog2(REGION_SIZE)-1:0]                RX_SOF_POS,
  input  logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]     RX_EOF_POS,
  input  logic                                          RX_SOF,
  input  logic                                          RX_EOF,
  input  logic                                          RX_SRC_RDY,
  output logic                                          RX_DST_RDY,

  output logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0]  TX_DATA,
  output logic [META_WIDTH-1:0]                         TX_META,
  output logic [$clog2(REGION_SIZE)-1:0]                TX_SOF_POS,
  output logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]     TX_EOF_POS,
  output logic                                          TX_SOF,
  output logic                                          TX_EOF,
  output logic                                          TX_SRC_RDY,
  input  logic                                          TX_DST_RDY,

  output logic [LEN_WIDTH-1:0]                          LEN_DATA,
  output logic [META_WIDTH-1:0]                         LEN_META,
  output logic                                          LEN_OVF,
  output logic                                          LEN_SRC_RDY,
  input  logic                                          LEN_DST_RDY
);

  logic     xfer;
  logic     emit;
  len_rec_t rec;

  // Accept only when both output registers can take a word; they then drain
  // independently.
  assign RX_DST_RDY = (!TX_SRC_RDY | TX_DST_RDY) & (!LEN_SRC_RDY | LEN_DST_RDY);
  assign xfer       = RX_SRC_RDY & RX_DST_RDY;

  mfb_len_acc #(
    .REGION_SIZE (REGION_SIZE),
    .BLOCK_SIZE  (BLOCK_SIZE),
    .W           (REGION_SIZE * BLOCK_SIZE),
    .META_WIDTH  (META_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH)
  ) u_acc (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .xfer    (xfer),
    .sof     (RX_SOF),
    .eof     (RX_EOF),
    .sof_pos (RX_SOF_POS),
    .eof_pos (RX_EOF_POS),
    .meta    (RX_META),
    .emit    (emit),
    .rec     (rec)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      TX_DATA     <= '0;
      TX_META     <= '0;
      TX_SOF_POS  <= '0;
      TX_EOF_POS  <= '0;
      TX_SOF      <= 1'b0;
      TX_EOF      <= 1'b0;
      TX_SRC_RDY  <= 1'b0;
      LEN_DATA    <= '0;
      LEN_META    <= '0;
      LEN_OVF     <= 1'b0;
      LEN_SRC_RDY <= 1'b0;
    end else begin
      if (xfer) begin
        TX_DATA    <= RX_DATA;
        TX_META    <= RX_META;
        TX_SOF_POS <= RX_SOF_POS;
        TX_EOF_POS <= RX_EOF_POS;
        TX_SOF     <= RX_SOF;
        TX_EOF     <= RX_EOF;
        TX_SRC_RDY <= 1'b1;
      end else if (TX_DST_RDY) begin
        TX_SRC_RDY <= 1'b0;
      end

      // xfer without emit implies LEN had room, so the old record is gone.
      if (xfer && emit) begin
        LEN_DATA    <= rec.len[LEN_WIDTH-1:0];
        LEN_META    <= rec.meta[META_WIDTH-1:0];
        LEN_OVF     <= rec.ovf;
        LEN_SRC_RDY <= 1'b1;
      end else if (LEN_DST_RDY) begin
        LEN_SRC_RDY <= 1'b0;
      end
    end
  end

  wire unused_rec = ^{rec.len[LEN_MAX-1:LEN_WIDTH], rec.meta[META_MAX-1:META_WIDTH]};

endmodule

// File: tb/tb_mfb_frame_len_meter.sv
// Bench for mfb_frame_len_meter: two instances (LEN_WIDTH 16 and 8) share
// the same RX stream and ready inputs; a scoreboard checks TX words and LEN
// records of both.
module tb_mfb_frame_len_meter;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic [7:0]    rx_meta = '0;
  logic [2:0]    rx_sof_pos = '0;
  logic [5:0]    rx_eof_pos = '0;
  logic          rx_sof = 1'b0, rx_eof = 1'b0, rx_src_rdy = 1'b0;
  logic          tx_dst_rdy = 1'b1, len_dst_rdy = 1'b1;

  logic          rx_dst_rdy_a, tx_sof_a, tx_eof_a, tx_src_rdy_a, len_ovf_a, len_src_rdy_a;
  logic [DW-1:0] tx_data_a;
  logic [7:0]    tx_meta_a, len_meta_a;
  logic [2:0]    tx_sof_pos_a;
  logic [5:0]    tx_eof_pos_a;
  logic [15:0]   len_data_a;

  logic          rx_dst_rdy_b, tx_sof_b, tx_eof_b, tx_src_rdy_b, len_ovf_b, len_src_rdy_b;
  logic [DW-1:0] tx_data_b;
  logic [7:0]    tx_meta_b, len_meta_b;
  logic [2:0]    tx_sof_pos_b;
  logic [5:0]    tx_eof_pos_b;
  logic [7:0]    len_data_b;

  mfb_frame_len_meter #(.LEN_WIDTH(16)) dut_a (
    .CLK(clk), .RESET_N(rst_n),
    .RX_DATA(rx_data), .RX_META(rx_meta), .RX_SOF_POS(rx_sof_pos), .RX_EOF_POS(rx_eof_pos),
    .RX_SOF(rx_sof), .RX_EOF(rx_eof), .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(rx_dst_rdy_a),
    .TX_DATA(tx_data_a), .TX_META(tx_meta_a), .TX_SOF_POS(tx_sof_pos_a), .TX_EOF_POS(tx_eof_pos_a),
    .TX_SOF(tx_sof_a), .TX_EOF(tx_eof_a), .TX_SRC_RDY(tx_src_rdy_a), .TX_DST_RDY(tx_dst_rdy),
    .LEN_DATA(len_data_a), .LEN_META(len_meta_a), .LEN_OVF(len_ovf_a),
    .LEN_SRC_RDY(len_src_rdy_a), .LEN_DST_RDY(len_dst_rdy)
  );

  mfb_frame_len_meter #(.LEN_WIDTH(8)) dut_b (
    .CLK(clk), .RESET_N(rst_n),
    .RX_DATA(rx_data), .RX_META(rx_meta), .RX_SOF_POS(rx_sof_pos), .RX_EOF_POS(rx_eof_pos),
    .RX_SOF(rx_sof), .RX_EOF(rx_eof), .RX_SRC_RDY(rx_src_rdy), .RX_DST_RDY(rx_dst_rdy_b),
    .TX_DATA(tx_data_b), .TX_META(tx_meta_b), .TX_SOF_POS(tx_sof_pos_b), .TX_EOF_POS(tx_eof_pos_b),
    .TX_SOF(tx_sof_b), .TX_EOF(tx_eof_b), .TX_SRC_RDY(tx_src_rdy_b), .TX_DST_RDY(tx_dst_rdy),
    .LEN_DATA(len_data_b), .LEN_META(len_meta_b), .LEN_OVF(len_ovf_b),
    .LEN_SRC_RDY(len_src_rdy_b), .LEN_DST_RDY(len_dst_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [7:0]    meta;
    logic [2:0]    sp;
    logic [5:0]    ep;
    logic          sof;
    logic          eof;
  } tx_t;
  typedef struct {
    int         len;
    logic [7:0] meta;
  } len_t;

  tx_t  txq[$];
  len_t lenq[$];
  tx_t  te;
  len_t le;

  int         vectors = 0;
  int         miscompares = 0;
  int         m_acc = 0;
  bit         m_in = 1'b0;
  logic [7:0] m_meta = '0;
  bit         rnd = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: a word/record leaves the DUT at a posedge where valid & ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_src_rdy_a && tx_dst_rdy) begin
        vectors++;
        assert (txq.size() != 0) else begin
          miscompares++;
          $error("FAIL tx_extra: got unexpected TX word, expected none");
        end
        if (txq.size() != 0) begin
          te = txq.pop_front();
          chk("tx_data", tx_data_a, te.data);
          chk("tx_ctl", DW'({tx_meta_a, tx_sof_pos_a, tx_eof_pos_a, tx_sof_a, tx_eof_a}),
              DW'({te.meta, te.sp, te.ep, te.sof, te.eof}));
        end
      end
      if (len_src_rdy_a && len_dst_rdy) begin
        vectors++;
        assert (lenq.size() != 0) else begin
          miscompares++;
          $error("FAIL len_extra: got unexpected record %0d, expected none", len_data_a);
        end
        if (lenq.size() != 0) begin
          le = lenq.pop_front();
          chk("len16", DW'({len_ovf_a, len_data_a, len_meta_a}),
              DW'({(le.len > 65535), 16'((le.len > 65535) ? 65535 : le.len), le.meta}));
          chk("len8", DW'({len_src_rdy_b, len_ovf_b, len_data_b, len_meta_b}),
              DW'({1'b1, (le.len > 255), 8'((le.len > 255) ? 255 : le.len), le.meta}));
        end
      end
    end
  end

  // Offer one word; returns at posedge+1 after it was accepted (or timed out).
  task automatic send_word(input bit sof, input bit eof, input int sp, input int ep,
                           input logic [7:0] meta);
    int n;
    int so;
    int en;
    tx_t w;
    for (int i = 0; i < DW/32; i++) rx_data[i*32 +: 32] = $urandom;
    rx_sof = sof; rx_eof = eof; rx_sof_pos = 3'(sp); rx_eof_pos = 6'(ep); rx_meta = meta;
    rx_src_rdy = 1'b1;
    n = 0;
    forever begin
      if (rnd) begin
        tx_dst_rdy  = 1'($urandom_range(0, 1));
        len_dst_rdy = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      if (rx_dst_rdy_a || n == 100) break;
      n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rx_src_rdy = 1'b0;
    vectors++;
    assert (n < 100) else begin
      miscompares++;
      $error("FAIL rx_timeout: got no RX_DST_RDY in %0d cycles, expected acceptance", n);
    end
    if (n < 100) begin
      w.data = rx_data; w.meta = meta; w.sp = 3'(sp); w.ep = 6'(ep); w.sof = sof; w.eof = eof;
      txq.push_back(w);
      so = sp * 8;
      en = ep + 1;
      if (sof && eof && !m_in) lenq.push_back('{en - so, meta});
      else begin
        if (eof && m_in) begin
          lenq.push_back('{m_acc + en, m_meta});
          m_in = 1'b0;
        end
        if (sof) begin
          m_acc = 64 - so; m_meta = meta; m_in = 1'b1;
        end else if (m_in) m_acc += 64;
      end
    end
  endtask

  task automatic idle(input int n);
    rx_src_rdy = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((txq.size() != 0 || lenq.size() != 0) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    assert (n < 300) else begin
      miscompares++;
      $error("FAIL drain: got %0d TX / %0d LEN outstanding, expected 0", txq.size(), lenq.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, sp, ep;
    logic [7:0] mt;

    // Reset state
    @(negedge clk);
    chk("rst_tx_vld",  DW'(tx_src_rdy_a),  '0);
    chk("rst_len_vld", DW'(len_src_rdy_a), '0);
    chk("rst_len_ovf", DW'(len_ovf_a),     '0);
    chk("rst_tx_data", tx_data_a,          '0);
    chk("rst_rx_rdy",  DW'(rx_dst_rdy_a),  DW'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // 1: single-word frame, 41 - 16 = 25; TX and LEN both valid one cycle later
    send_word(1, 1, 2, 40, 8'hA1);
    chk("t1_tx_lat",  DW'(tx_src_rdy_a),  DW'(1));
    chk("t1_len_lat", DW'(len_src_rdy_a), DW'(1));
    chk("t1_len",     DW'(len_data_a),    DW'(25));
    idle(2);

    // 2: three-word frame, 64 + 64 + 10 = 138
    send_word(1, 0, 0, 0, 8'hB2);
    send_word(0, 0, 0, 0, 8'h00);
    send_word(0, 1, 0, 9, 8'h00);
    idle(2);

    // 3: A opened at block 4 (32); shared word closes A (40) and opens B at block 2
    send_word(1, 0, 4, 0, 8'hC3);
    send_word(1, 1, 2, 7, 8'hC4);
    send_word(0, 1, 0, 63, 8'h00);    // B = 48 + 64 = 112
    idle(2);

    // 4: record held 5 cycles; RX stalls, TX drains, record stable (21 - 8 = 13)
    len_dst_rdy = 1'b0;
    send_word(1, 1, 1, 20, 8'h44);
    rx_sof = 1'b1; rx_eof = 1'b1; rx_sof_pos = 3'd0; rx_eof_pos = 6'd9; rx_src_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rx_rdy",   DW'(rx_dst_rdy_a),  '0);
      chk("bp_len_vld",  DW'(len_src_rdy_a), DW'(1));
      chk("bp_len_data", DW'(len_data_a),    DW'(13));
      chk("bp_tx_vld",   DW'(tx_src_rdy_a),  DW'(i == 0));
      @(posedge clk); #1;
    end
    len_dst_rdy = 1'b1;
    send_word(1, 1, 0, 9, 8'h55);
    idle(2);

    // 5: 320-item frame saturates the 8-bit instance, next frame is clean
    send_word(1, 0, 0, 0, 8'h66);
    repeat (3) send_word(0, 0, 0, 0, 8'h00);
    send_word(0, 1, 0, 63, 8'h00);
    send_word(1, 1, 0, 9, 8'h67);
    idle(2);
    drain();

    // 6: reset mid-frame with a TX word pending
    send_word(1, 0, 0, 0, 8'h77);
    send_word(0, 0, 0, 0, 8'h00);
    rst_n = 1'b0;
    txq.delete(); lenq.delete(); m_in = 1'b0; m_acc = 0;
    @(negedge clk);
    chk("rst2_tx_vld",  DW'(tx_src_rdy_a),  '0);
    chk("rst2_len_vld", DW'(len_src_rdy_a), '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_word(1, 1, 0, 9, 8'h78);
    idle(2);

    // Random frames under random TX/LEN backpressure
    rnd = 1'b1;
    for (int f = 0; f < 40; f++) begin
      nw = $urandom_range(1, 6);
      mt = 8'($urandom);
      sp = $urandom_range(0, 7);
      if (nw == 1) begin
        ep = $urandom_range(63, sp * 8);
        send_word(1, 1, sp, ep, mt);
      end else begin
        send_word(1, 0, sp, $urandom_range(0, 63), mt);
        for (int k = 0; k < nw - 2; k++) send_word(0, 0, $urandom_range(0, 7), $urandom_range(0, 63), 8'($urandom));
        send_word(0, 1, $urandom_range(0, 7), $urandom_range(0, 63), 8'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rnd = 1'b0;
    tx_dst_rdy = 1'b1;
    len_dst_rdy = 1'b1;
    idle(1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
